// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Front-end stage feeding the instruction decoder. Owns the PC and the
//   one-hot phase ring f -> r -> x -> m -> w. Fetches one 32-bit word per
//   instruction over a req/ack port, holds it in ir, and in w either advances
//   the PC by the opcode-derived length or redirects on a taken branch.
//   An HLT opcode (0xF4) stops the sequencer until reset.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     fetch request and byte address (= pc), held until ack
//   imem_ack/rdata    fetch data valid; addr byte in rdata[31:24]
//   br_taken/target   branch redirect, sampled only in w
//   mem_stall         holds phase m while high
//   ir                current instruction register
//   phase             one-hot phase: bit0=f, 1=r, 2=x, 3=m, 4=w
//   pc                address of the current instruction
//   halted            sticky halt flag
//   retired           one-cycle pulse in the cycle after each w
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            mem_stall,
  output logic [31:0]     ir,
  output logic [4:0]      phase,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            retired
);

  typedef enum logic [4:0] {
    PH_F = 5'b00001,
    PH_R = 5'b00010,
    PH_X = 5'b00100,
    PH_M = 5'b01000,
    PH_W = 5'b10000
  } phase_e;

  phase_e          r_phase, w_phase_nxt;
  logic [31:0]     r_ir;
  logic [PC_W-1:0] r_pc;
  logic            r_halted;
  logic            r_retired;

  logic            w_fetch_acc;
  logic            w_is_hlt;
  logic [2:0]      w_len;

  // rst_n gates the request directly so it drops the instant reset asserts,
  // even in the middle of an outstanding fetch.
  assign imem_req    = rst_n & r_phase[0] & ~r_halted;
  assign imem_addr   = r_pc;
  assign w_fetch_acc = imem_req & imem_ack;
  assign w_is_hlt    = (r_ir[31:24] == 8'hF4);

  // Instruction length from the leading opcode byte; unknown opcodes are 2.
  always_comb begin
    w_len = 3'd2;
    case (r_ir[31:24])
      8'h83, 8'hC1, 8'h66, 8'h90: w_len = 3'd3;
      8'hF4:                      w_len = 3'd1;
      default:                    w_len = 3'd2;
    endcase
  end

  // Next phase. While halted the request is low, so f never accepts a fetch
  // and the ring parks in f.
  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_F:    if (w_fetch_acc) w_phase_nxt = PH_R;
      PH_R:    w_phase_nxt = PH_X;
      PH_X:    w_phase_nxt = PH_M;
      PH_M:    if (!mem_stall) w_phase_nxt = PH_W;
      PH_W:    w_phase_nxt = PH_F;
      default: w_phase_nxt = PH_F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= PH_F;
      r_ir      <= '0;
      r_pc      <= RESET_PC;
      r_halted  <= 1'b0;
      r_retired <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_retired <= (r_phase == PH_W);
      if (w_fetch_acc) r_ir <= imem_rdata;
      if (r_phase == PH_W) begin
        // HLT keeps pc on its own address and overrides any branch.
        if (w_is_hlt)      r_halted <= 1'b1;
        else if (br_taken) r_pc     <= br_target;
        else               r_pc     <= r_pc + {{(PC_W-3){1'b0}}, w_len};
      end
    end
  end

  assign ir      = r_ir;
  assign phase   = r_phase;
  assign pc      = r_pc;
  assign halted  = r_halted;
  assign retired = r_retired;

endmodule
